// File: rtl/char_pkg.sv
// Shared definitions for the character generator.
//   DefWidth / DefDepth : default character width and buffer depth
//   state_e             : FSM state encoding (idle, sending, done)
package char_pkg;

   localparam int unsigned DefWidth = 8;
   localparam int unsigned DefDepth = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/char_gen_if.sv
// Bus bundle between a character source/sink and char_gen.
//   wr_en, wr_char     : load one character into the buffer
//   start              : begin emitting the buffered string
//   out_ready          : sink accepts out_char this cycle
//   out_valid/out_char : emitted character and its qualifier
//   out_last           : current character is the final one
//   busy, full, count  : status (FSM not idle, buffer full, characters loaded)
// master: the side that drives loads/start/ready; slave: char_gen itself.
interface char_gen_if #(
   parameter int unsigned WIDTH = char_pkg::DefWidth,
   parameter int unsigned DEPTH = char_pkg::DefDepth
) ();

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             wr_en;
   logic [WIDTH-1:0] wr_char;
   logic             start;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_char;
   logic             out_last;
   logic             busy;
   logic             full;
   logic [CW-1:0]    count;

   modport master (
      output wr_en, wr_char, start, out_ready,
      input  out_valid, out_char, out_last, busy, full, count
   );

   modport slave (
      input  wr_en, wr_char, start, out_ready,
      output out_valid, out_char, out_last, busy, full, count
   );

endinterface

// File: rtl/char_buf.sv
// DEPTH x WIDTH character store: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write character
//   raddr_i : read index
//   rdata_o : character at raddr_i (combinational)
module char_buf #(
   parameter int unsigned WIDTH = char_pkg::DefWidth,
   parameter int unsigned DEPTH = char_pkg::DefDepth,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/char_gen.sv
// Character string generator: characters are loaded into a buffer while idle,
// then a start pulse streams them out with a valid/ready handshake, flagging
// the final character. One idle-recovery (done) cycle follows each string.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : char_gen_if slave (loads, start, output stream, status)
module char_gen #(
   parameter int unsigned WIDTH = char_pkg::DefWidth,
   parameter int unsigned DEPTH = char_pkg::DefDepth
) (
   input logic       clk,
   input logic       reset,
   char_gen_if.slave bus
);

   import char_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   state_e           state_q;
   logic [CW-1:0]    count_q;
   logic [AW-1:0]    rd_idx_q;

   logic             full;
   logic             wr_ok;
   logic             sending;
   logic             last;
   logic [WIDTH-1:0] rd_char;

   assign full    = (count_q == FullCount);
   assign wr_ok   = (state_q == StIdle) && bus.wr_en && !full;
   assign sending = (state_q == StSend);
   // count_q >= 1 whenever sending, so count_q - 1 cannot underflow here
   assign last    = sending && ({1'b0, rd_idx_q} == (count_q - 1'b1));

   char_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk_i   (clk),
      .we_i    (wr_ok),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (bus.wr_char),
      .raddr_i (rd_idx_q),
      .rdata_o (rd_char)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         count_q  <= '0;
         rd_idx_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (wr_ok) begin
                  count_q <= count_q + 1'b1;
               end
               // Decision uses the pre-write count; a same-cycle write still
               // joins the string because count_q is updated alongside.
               if (bus.start && (count_q != '0)) begin
                  state_q  <= StSend;
                  rd_idx_q <= '0;
               end
            end
            StSend: begin
               if (bus.out_ready) begin
                  if (last) begin
                     state_q <= StDone;
                  end else begin
                     rd_idx_q <= rd_idx_q + 1'b1;
                  end
               end
            end
            StDone: begin
               state_q  <= StIdle;
               count_q  <= '0;
               rd_idx_q <= '0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.out_valid = sending;
   assign bus.out_char  = rd_char;
   assign bus.out_last  = last;
   assign bus.busy      = (state_q != StIdle);
   assign bus.full      = full;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_char_gen.sv
// Self-checking bench for char_gen: directed scenarios plus randomized
// load/emit sessions checked against a string-queue reference model.
module tb_char_gen;

   localparam int unsigned W = 8;
   localparam int unsigned D = 8;

   logic clk;
   logic reset;

   char_gen_if #(.WIDTH(W), .DEPTH(D)) bus ();

   char_gen #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the string the DUT should currently hold.
   logic [W-1:0] mq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at negedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input logic [W-1:0] c);
      chk("load_count", 32'(bus.count), 32'(mq.size()));
      chk("load_full", 32'(bus.full), 32'(mq.size() == D));
      bus.wr_en   = 1'b1;
      bus.wr_char = c;
      if (mq.size() < D) mq.push_back(c);
      cyc();
      bus.wr_en = 1'b0;
   endtask

   // Stream the modelled string out; optionally pulses start first, applies
   // random back-pressure and random spurious wr_en/start during SEND.
   task automatic run_string(input bit do_start, input bit rnd_ready, input bit noise);
      int i = 0;
      int budget = 0;
      int n = mq.size();
      if (do_start) begin
         bus.start     = 1'b1;
         bus.out_ready = 1'b1;
         cyc();
         bus.start = 1'b0;
      end
      while (i < n && budget < 200) begin
         budget++;
         bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (noise) begin
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_char = W'($urandom_range(0, 255));
            bus.start   = 1'($urandom_range(0, 1));
         end
         chk("send_valid", 32'(bus.out_valid), 32'd1);
         chk("send_char", 32'(bus.out_char), 32'(mq[i]));
         chk("send_last", 32'(bus.out_last), 32'(i == n - 1));
         chk("send_count", 32'(bus.count), 32'(n));
         chk("send_busy", 32'(bus.busy), 32'd1);
         if (bus.out_ready) i++;
         cyc();
      end
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      chk("send_complete", 32'(i), 32'(n));
      chk("done_valid", 32'(bus.out_valid), 32'd0);
      chk("done_last", 32'(bus.out_last), 32'd0);
      chk("done_busy", 32'(bus.busy), 32'd1);
      cyc();
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_count", 32'(bus.count), 32'd0);
      mq.delete();
   endtask

   initial begin
      reset         = 1'b1;
      bus.wr_en     = 1'b0;
      bus.wr_char   = '0;
      bus.start     = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      cyc();
      cyc();
      reset = 1'b0;

      // Reset state
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_last", 32'(bus.out_last), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);

      // Scenario 1: "abc" at full rate
      load("a"); load("b"); load("c");
      run_string(1'b1, 1'b0, 1'b0);

      // Scenario 2: ninth load dropped
      for (int k = 0; k < 9; k++) load(W'(8'h30 + k));
      chk("full_flag", 32'(bus.full), 32'd1);
      chk("full_count", 32'(bus.count), 32'(D));
      run_string(1'b1, 1'b0, 1'b0);

      // Scenario 3: stall on 'a' for three cycles
      load("a"); load("b");
      bus.start     = 1'b1;
      bus.out_ready = 1'b0;
      cyc();
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_char", 32'(bus.out_char), 32'("a"));
         chk("stall_last", 32'(bus.out_last), 32'd0);
         cyc();
      end
      run_string(1'b0, 1'b0, 1'b0);

      // Scenario 4: reset while second of four characters is shown
      load("p"); load("q"); load("r"); load("s");
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("r4_char0", 32'(bus.out_char), 32'("p"));
      cyc();
      chk("r4_char1", 32'(bus.out_char), 32'("q"));
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      mq.delete();
      chk("r4_valid", 32'(bus.out_valid), 32'd0);
      chk("r4_last", 32'(bus.out_last), 32'd0);
      chk("r4_busy", 32'(bus.busy), 32'd0);
      chk("r4_count", 32'(bus.count), 32'd0);
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("r4_start_ignored", 32'(bus.busy), 32'd0);

      // Scenario 5: empty start ignored; start together with a write
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      chk("s5_empty_busy", 32'(bus.busy), 32'd0);
      chk("s5_empty_valid", 32'(bus.out_valid), 32'd0);
      load("a");
      bus.wr_en   = 1'b1;
      bus.wr_char = "x";
      bus.start   = 1'b1;
      bus.out_ready = 1'b1;
      mq.push_back("x");
      cyc();
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      run_string(1'b0, 1'b0, 1'b0);

      // Scenario 6: wr_en/start noise during SEND
      load("k"); load("l"); load("m");
      run_string(1'b1, 1'b0, 1'b1);

      // Randomized sessions
      for (int s = 0; s < 25; s++) begin
         int n;
         n = int'($urandom_range(0, D + 2));
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) cyc();
            load(W'($urandom_range(0, 255)));
         end
         if (mq.size() == 0) begin
            bus.start = 1'b1;
            cyc();
            bus.start = 1'b0;
            chk("rnd_empty_busy", 32'(bus.busy), 32'd0);
         end else begin
            run_string(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
